// File: rtl/game_pkg.sv
// Shared types and screen constants for the player motion logic.
package game_pkg;

  // Default coordinate widths and playfield limits
  localparam int DEF_XW        = 10;
  localparam int DEF_YW        = 9;
  localparam int SCREEN_X_MAX  = 199;
  localparam int SCREEN_KILL_Y = 250;

  // Bit positions of the buttons inside the packed button bus
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_JUMP  = 2;
  localparam int NUM_BTN   = 3;

  typedef logic [DEF_XW-1:0] coord_x_t;
  typedef logic [DEF_YW-1:0] coord_y_t;

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } motion_state_e;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for button levels, sampled only on movement ticks.
// While hold is high the history is frozen, so a press made during a
// pause is still seen as a fresh edge when movement resumes.
module tick_edge_detect #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         hold,
  input  logic [N-1:0] btn,
  output logic [N-1:0] edges
);

  logic [N-1:0] prev_reg;
  logic         sample;

  assign sample = tick && !hold;

  // Remember the button levels seen on the last acting tick
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= '0;
    end else if (sample) begin
      prev_reg <= btn;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign edges[gi] = sample && btn[gi] && !prev_reg[gi];
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player position / physics controller: edge-triggered left/right/jump,
// periodic gravity, map advance at the right border and fall-death latch.
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int XW          = DEF_XW,
  parameter int YW          = DEF_YW,
  parameter int NUM_MAPS    = 2,
  parameter int MAPW        = 1,
  parameter int X_INIT      = 20,
  parameter int Y_INIT      = 20,
  parameter int X_MAX       = SCREEN_X_MAX,
  parameter int STEP_X      = 15,
  parameter int JUMP_Y      = 20,
  parameter int GRAV_Y      = 15,
  parameter int GRAV_PERIOD = 20,
  parameter int KILL_Y      = SCREEN_KILL_Y
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            enable,
  input  logic            freeze,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_jump,
  output logic [XW-1:0]   char_x,
  output logic [YW-1:0]   char_y,
  output logic [MAPW-1:0] map_sel,
  output logic            map_adv,
  output logic            fell
);

  localparam int CW = $clog2(GRAV_PERIOD + 1);

  // Constants widened by one bit so sums and compares cannot wrap
  localparam logic [XW:0]     STEP_XW  = (XW + 1)'(STEP_X);
  localparam logic [XW:0]     X_MAX_W  = (XW + 1)'(X_MAX);
  localparam logic [YW:0]     JUMP_YW  = (YW + 1)'(JUMP_Y);
  localparam logic [YW:0]     GRAV_YW  = (YW + 1)'(GRAV_Y);
  localparam logic [YW:0]     KILL_YW  = (YW + 1)'(KILL_Y);
  localparam logic [YW:0]     Y_SAT    = {1'b0, {YW{1'b1}}};
  localparam logic [MAPW-1:0] MAP_LAST = MAPW'(NUM_MAPS - 1);
  localparam logic [CW-1:0]   GRAV_P   = CW'(GRAV_PERIOD);

  motion_state_e   state_reg, state_next;
  logic [XW-1:0]   x_reg, x_next;
  logic [YW-1:0]   y_reg, y_next;
  logic [MAPW-1:0] map_reg, map_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            adv_reg, adv_next;
  logic            fell_reg, fell_next;

  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] edges;
  logic               hold;
  logic               run_step;
  logic [YW:0]        y_fall;

  assign btn      = {btn_jump, btn_right, btn_left};
  assign hold     = freeze || (state_reg == DEAD) || !enable;
  assign run_step = tick && !hold;
  assign y_fall   = {1'b0, y_reg} + GRAV_YW;

  tick_edge_detect #(
    .N(NUM_BTN)
  ) u_edge (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .hold  (hold),
    .btn   (btn),
    .edges (edges)
  );

  // One movement action per acting tick, plus gravity counter and fall check
  always_comb begin
    x_next    = x_reg;
    y_next    = y_reg;
    map_next  = map_reg;
    cnt_next  = cnt_reg;
    adv_next  = 1'b0;
    fell_next = fell_reg;
    if (run_step) begin
      if (edges[BTN_LEFT]) begin
        x_next = ({1'b0, x_reg} >= STEP_XW) ? (x_reg - STEP_XW[XW-1:0]) : '0;
      end else if (edges[BTN_RIGHT]) begin
        if (({1'b0, x_reg} + STEP_XW) <= X_MAX_W) begin
          x_next = x_reg + STEP_XW[XW-1:0];
        end else if (map_reg < MAP_LAST) begin
          x_next   = '0;
          map_next = map_reg + MAPW'(1);
          adv_next = 1'b1;
        end else begin
          x_next = X_MAX_W[XW-1:0];
        end
      end else if (edges[BTN_JUMP]) begin
        y_next = ({1'b0, y_reg} >= JUMP_YW) ? (y_reg - JUMP_YW[YW-1:0]) : '0;
      end else if (cnt_reg == GRAV_P) begin
        y_next = (y_fall > Y_SAT) ? Y_SAT[YW-1:0] : y_fall[YW-1:0];
      end
      // Any held button (not just an edge) restarts the idle period
      if (|btn || (cnt_reg == GRAV_P)) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
      if ({1'b0, y_next} >= KILL_YW) begin
        fell_next = 1'b1;
      end
    end
  end

  // Enter DEAD on the same tick the fall latch sets; only reset leaves it
  always_comb begin
    state_next = state_reg;
    if ((state_reg == RUN) && fell_next) begin
      state_next = DEAD;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      x_reg     <= XW'(X_INIT);
      y_reg     <= YW'(Y_INIT);
      map_reg   <= '0;
      cnt_reg   <= '0;
      adv_reg   <= 1'b0;
      fell_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      map_reg   <= map_next;
      cnt_reg   <= cnt_next;
      adv_reg   <= adv_next;
      fell_reg  <= fell_next;
    end
  end

  assign char_x  = x_reg;
  assign char_y  = y_reg;
  assign map_sel = map_reg;
  assign map_adv = adv_reg;
  assign fell    = fell_reg;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: vector table, directed
// corner sequences and randomized stimulus against a behavioural model.
module tb_player_motion_ctrl;

  localparam int STEP_X = 15, JUMP_Y = 20, GRAV_Y = 15, PERIOD = 20;
  localparam int X_MAX = 199, KILL_Y = 250, NUM_MAPS = 2, Y_LIM = 511;

  logic       clk, reset, tick, enable, freeze;
  logic       btn_left, btn_right, btn_jump;
  logic [9:0] char_x;
  logic [8:0] char_y;
  logic [0:0] map_sel;
  logic       map_adv, fell;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (plain integers)
  int m_x, m_y, m_map, m_cnt;
  bit m_adv, m_fell, m_dead, m_pl, m_pr, m_pj;

  typedef struct {
    bit l;
    bit r;
    bit j;
    int ex;
    int ey;
  } vec_t;
  vec_t tbl[13];

  player_motion_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .enable    (enable),
    .freeze    (freeze),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_jump  (btn_jump),
    .char_x    (char_x),
    .char_y    (char_y),
    .map_sel   (map_sel),
    .map_adv   (map_adv),
    .fell      (fell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model of one clock edge, written directly from the movement rules
  task automatic model_clk(input bit rst, input bit tk, input bit en, input bit frz,
                           input bit l, input bit r, input bit j);
    bit el, er, ej, grav;
    m_adv = 0;
    if (rst) begin
      m_x = 20; m_y = 20; m_map = 0; m_cnt = 0;
      m_fell = 0; m_dead = 0; m_pl = 0; m_pr = 0; m_pj = 0;
    end else if (tk && !frz && !m_dead && en) begin
      el = l && !m_pl; er = r && !m_pr; ej = j && !m_pj;
      m_pl = l; m_pr = r; m_pj = j;
      grav = 0;
      if (el) m_x = (m_x - STEP_X < 0) ? 0 : m_x - STEP_X;
      else if (er) begin
        if (m_x + STEP_X <= X_MAX) m_x = m_x + STEP_X;
        else if (m_map < NUM_MAPS - 1) begin m_x = 0; m_map++; m_adv = 1; end
        else m_x = X_MAX;
      end
      else if (ej) m_y = (m_y - JUMP_Y < 0) ? 0 : m_y - JUMP_Y;
      else if (m_cnt == PERIOD) begin
        m_y = (m_y + GRAV_Y > Y_LIM) ? Y_LIM : m_y + GRAV_Y;
        grav = 1;
      end
      m_cnt = (l || r || j || grav) ? 0 : m_cnt + 1;
      if (m_y >= KILL_Y) begin m_fell = 1; m_dead = 1; end
    end
  endtask

  task automatic cyc(input bit rst, input bit tk, input bit en, input bit frz,
                     input bit l, input bit r, input bit j);
    reset = rst; tick = tk; enable = en; freeze = frz;
    btn_left = l; btn_right = r; btn_jump = j;
    @(posedge clk);
    model_clk(rst, tk, en, frz, l, r, j);
    #1;
    reset = 0; tick = 0;
  endtask

  task automatic do_reset();
    cyc(1, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 1, 1, 0, 0, 0, 0);
  endtask

  // Press for one tick then release for one tick
  task automatic tap(input bit l, input bit r, input bit j);
    cyc(0, 1, 1, 0, l, r, j);
    cyc(0, 1, 1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 0; tick = 0; enable = 1; freeze = 0;
    btn_left = 0; btn_right = 0; btn_jump = 0;
    @(posedge clk); #1;

    // Reset values
    do_reset();
    chk("rst_x", int'(char_x), 20);
    chk("rst_y", int'(char_y), 20);
    chk("rst_map", int'(map_sel), 0);
    chk("rst_adv", int'(map_adv), 0);
    chk("rst_fell", int'(fell), 0);

    // Vector table: consecutive ticks from reset
    tbl[0]  = '{1, 0, 0, 5, 20};
    tbl[1]  = '{1, 0, 0, 5, 20};
    tbl[2]  = '{1, 0, 0, 5, 20};
    tbl[3]  = '{0, 0, 0, 5, 20};
    tbl[4]  = '{1, 0, 0, 0, 20};
    tbl[5]  = '{0, 0, 0, 0, 20};
    tbl[6]  = '{0, 1, 0, 15, 20};
    tbl[7]  = '{0, 1, 0, 15, 20};
    tbl[8]  = '{0, 0, 1, 15, 0};
    tbl[9]  = '{0, 0, 0, 15, 0};
    tbl[10] = '{0, 1, 1, 30, 0};
    tbl[11] = '{0, 0, 0, 30, 0};
    tbl[12] = '{1, 1, 1, 15, 0};
    for (int i = 0; i < 13; i++) begin
      cyc(0, 1, 1, 0, tbl[i].l, tbl[i].r, tbl[i].j);
      $display("vec %0d l=%0d r=%0d j=%0d -> x=%0d y=%0d", i, tbl[i].l, tbl[i].r,
               tbl[i].j, char_x, char_y);
      chk($sformatf("tbl%0d_x", i), int'(char_x), tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), int'(char_y), tbl[i].ey);
      chk($sformatf("tbl%0d_adv", i), int'(map_adv), 0);
    end

    // Map advance at the right border, then clamp on the last map
    do_reset();
    tap(1, 0, 0); tap(1, 0, 0);
    repeat (13) tap(0, 1, 0);
    chk("m0_x195", int'(char_x), 195);
    cyc(0, 1, 1, 0, 0, 1, 0);
    chk("adv_x", int'(char_x), 0);
    chk("adv_map", int'(map_sel), 1);
    chk("adv_pulse", int'(map_adv), 1);
    cyc(0, 0, 1, 0, 0, 1, 0);
    chk("adv_one_clk", int'(map_adv), 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    repeat (13) tap(0, 1, 0);
    chk("m1_x195", int'(char_x), 195);
    cyc(0, 1, 1, 0, 0, 1, 0);
    chk("m1_clamp_x", int'(char_x), 199);
    chk("m1_no_adv", int'(map_adv), 0);
    chk("m1_map", int'(map_sel), 1);
    $display("seq map_advance done x=%0d map=%0d", char_x, map_sel);

    // Gravity cadence and fall death
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      idle(20);
      chk($sformatf("grav%0d_before", k), int'(char_y), 20 + 15 * (k - 1));
      idle(1);
      chk($sformatf("grav%0d_y", k), int'(char_y), 20 + 15 * k);
      chk($sformatf("grav%0d_fell", k), int'(fell), (k == 16) ? 1 : 0);
    end
    chk("grav_x", int'(char_x), 20);
    tap(1, 0, 0); tap(0, 1, 0); tap(0, 0, 1); idle(30);
    chk("dead_x", int'(char_x), 20);
    chk("dead_y", int'(char_y), 260);
    chk("dead_fell", int'(fell), 1);
    $display("seq gravity_fall done y=%0d fell=%0d", char_y, fell);

    // Simultaneous left+jump, then a later jump
    do_reset();
    tap(1, 0, 0);
    repeat (3) tap(0, 1, 0);
    idle(168);
    chk("setup_y140", int'(char_y), 140);
    tap(0, 0, 1); tap(0, 0, 1);
    chk("setup_x", int'(char_x), 50);
    chk("setup_y", int'(char_y), 100);
    cyc(0, 1, 1, 0, 1, 0, 1);
    chk("lj_x", int'(char_x), 35);
    chk("lj_y", int'(char_y), 100);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 1);
    chk("jump_y", int'(char_y), 80);
    $display("seq left_jump done x=%0d y=%0d", char_x, char_y);

    // Freeze holds the gravity counter; disable holds edge history
    do_reset();
    idle(5);
    repeat (40) cyc(0, 1, 1, 1, 0, 0, 0);
    chk("frz_y", int'(char_y), 20);
    idle(15);
    chk("frz_y_15", int'(char_y), 20);
    idle(1);
    chk("frz_grav", int'(char_y), 35);
    repeat (3) cyc(0, 1, 0, 0, 1, 0, 0);
    chk("dis_x", int'(char_x), 20);
    cyc(0, 1, 1, 0, 1, 0, 0);
    chk("dis_edge_x", int'(char_x), 5);
    do_reset();
    chk("mid_rst_x", int'(char_x), 20);
    chk("mid_rst_y", int'(char_y), 20);
    chk("mid_rst_map", int'(map_sel), 0);
    chk("mid_rst_fell", int'(fell), 0);
    $display("seq freeze_enable_reset done");

    // Randomized stimulus against the model
    do_reset();
    for (int blk = 0; blk < 25; blk++) begin
      int dens;
      dens = ($urandom_range(0, 1) == 0) ? 40 : 5;
      for (int c = 0; c < 200; c++) begin
        bit rst, tk, en, frz, l, r, j;
        rst = ($urandom_range(0, 499) == 0);
        tk  = ($urandom_range(0, 1) == 1);
        en  = ($urandom_range(0, 9) != 0);
        frz = ($urandom_range(0, 24) == 0);
        l   = ($urandom_range(0, dens - 1) == 0);
        r   = ($urandom_range(0, dens - 1) == 0);
        j   = ($urandom_range(0, dens - 1) == 0);
        cyc(rst, tk, en, frz, l, r, j);
        chk("rnd_x", int'(char_x), m_x);
        chk("rnd_y", int'(char_y), m_y);
        chk("rnd_map", int'(map_sel), m_map);
        chk("rnd_adv", int'(map_adv), int'(m_adv));
        chk("rnd_fell", int'(fell), int'(m_fell));
      end
      if (m_dead && ($urandom_range(0, 1) == 1)) do_reset();
    end
    $display("random phase done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
